hq_codebook_mult: RTL and testbench

Parametrised complex matrix multiplier for the precoder-search datapath. It buffers one NR×NT channel matrix H, then computes Hq = H·S_q for a programmable range of codebook matrices S_q (NT×NS, complex Q-format), streaming every Hq element out over a ready/valid interface. It replaces the fixed 4×4×2, 16-entry multiplier and adds several features: a writable codebook, H reuse, a selectable q range, rounding/saturation and output backpressure.

---
 rtl/hq_codebook_mult_pkg.sv | 21 ++
 rtl/hq_codebook_mult_if.sv | 32 +++
 rtl/hq_codebook_mult_c_mac_acc.sv | 38 +++
 rtl/hq_codebook_mult.sv | 99 +++++++++
 tb/tb_hq_codebook_mult.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hq_codebook_mult_pkg.sv
// hq_pkg: FSM states, default sizes, derived index widths and the round-half-up/saturate helper
package hq_pkg;
  localparam int N_DEF = 16;
  localparam int Q_DEF = 8;
  localparam int NR_DEF = 4;
  localparam int NT_DEF = 4;
  localparam int NS_DEF = 2;
  localparam int NQ_DEF = 16;
  localparam int ACC_DEF = 36;
  localparam int QW_DEF = $clog2(NQ_DEF);
  localparam int RW_DEF = $clog2(NR_DEF);
  localparam int KW_DEF = $clog2(NT_DEF);
  localparam int JW_DEF = $clog2(NS_DEF);
  typedef enum logic [2:0] {IDLE, LOAD_H, CALC, OUT, DONE} state_t;
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] a, input int q, input int n);
    logic signed [63:0] r, hi;
    r = (a + (64'sd1 <<< (q - 1))) >>> q;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    return r > hi ? hi : r < -hi - 64'sd1 ? -hi - 64'sd1 : r;
  endfunction
endpackage

// File: rtl/hq_codebook_mult_if.sv
// hq_codebook_mult_if: job control, H stream, codebook write port and tagged result stream (master drives jobs, slave is the multiplier)
interface hq_codebook_mult_if import hq_pkg::*; #(
  parameter int N = N_DEF,
  parameter int QW = QW_DEF,
  parameter int RW = RW_DEF,
  parameter int KW = KW_DEF,
  parameter int JW = JW_DEF
);
  logic start, reuse_h;
  logic [QW-1:0] q_first, q_last;
  logic h_valid, h_ready;
  logic signed [N-1:0] h_in_r, h_in_i;
  logic cb_wr_en;
  logic [QW+KW+JW-1:0] cb_wr_addr;
  logic signed [N-1:0] cb_wr_r, cb_wr_i;
  logic out_valid, out_ready;
  logic signed [N-1:0] out_r, out_i;
  logic [QW-1:0] out_q;
  logic [RW-1:0] out_row;
  logic [JW-1:0] out_col;
  logic matrix_done, all_done, busy;
  modport master (
    output start, reuse_h, q_first, q_last, h_valid, h_in_r, h_in_i,
    output cb_wr_en, cb_wr_addr, cb_wr_r, cb_wr_i, out_ready,
    input h_ready, out_valid, out_r, out_i, out_q, out_row, out_col, matrix_done, all_done, busy
  );
  modport slave (
    input start, reuse_h, q_first, q_last, h_valid, h_in_r, h_in_i,
    input cb_wr_en, cb_wr_addr, cb_wr_r, cb_wr_i, out_ready,
    output h_ready, out_valid, out_r, out_i, out_q, out_row, out_col, matrix_done, all_done, busy
  );
endinterface

// File: rtl/hq_codebook_mult_c_mac_acc.sv
// c_mac_acc: complex MAC (clr restarts the sum with this cycle's product); ports clk, rst(active-low), clr, en, a/b operands, rounded+saturated yr/yi
module c_mac_acc import hq_pkg::*; #(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF,
  parameter int ACC_WIDTH = ACC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic signed [N-1:0] ar,
  input  logic signed [N-1:0] ai,
  input  logic signed [N-1:0] br,
  input  logic signed [N-1:0] bi,
  output logic signed [N-1:0] yr,
  output logic signed [N-1:0] yi
);
  logic signed [2*N-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_WIDTH-1:0] acc_r_q, acc_i_q, acc_r_d, acc_i_d;
  always_comb begin
    p_rr = ar * br;
    p_ii = ai * bi;
    p_ri = ar * bi;
    p_ir = ai * br;
    acc_r_d = (clr ? '0 : acc_r_q) + (en ? ACC_WIDTH'(p_rr) - ACC_WIDTH'(p_ii) : '0);
    acc_i_d = (clr ? '0 : acc_i_q) + (en ? ACC_WIDTH'(p_ri) + ACC_WIDTH'(p_ir) : '0);
    yr = N'(round_sat(64'(acc_r_q), Q, N));
    yi = N'(round_sat(64'(acc_i_q), Q, N));
  end
  always_ff @(posedge clk)
    if (!rst) begin
      acc_r_q <= '0;
      acc_i_q <= '0;
    end else begin
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
    end
endmodule

// File: rtl/hq_codebook_mult.sv
// hq_codebook_mult: Hq = H*S_q over q_first..q_last; ports clk, rst(sync active-low), bus (job start, H stream, codebook writes, tagged result stream)
module hq_codebook_mult import hq_pkg::*; #(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF,
  parameter int NR = NR_DEF,
  parameter int NT = NT_DEF,
  parameter int NS = NS_DEF,
  parameter int NQ = NQ_DEF,
  parameter int ACC_WIDTH = ACC_DEF
) (
  input logic clk,
  input logic rst,
  hq_codebook_mult_if.slave bus
);
  localparam int QW = $clog2(NQ);
  localparam int RW = $clog2(NR);
  localparam int KW = $clog2(NT);
  localparam int JW = $clog2(NS);
  state_t state_q, state_d;
  logic [QW-1:0] q_q, q_last_q;
  logic [RW-1:0] i_q;
  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic [RW+KW-1:0] h_cnt_q;
  logic [2*N-1:0] h_mem [NR*NT];
  logic [2*N-1:0] cb_mem [NQ*NT*NS];
  logic [2*N-1:0] h_rd, cb_rd;
  logic hs, last_k, last_i, last_j;
  logic signed [N-1:0] y_r, y_i;
  always_comb begin
    hs = state_q == OUT && bus.out_ready;
    last_k = k_q == KW'(NT - 1);
    last_i = i_q == RW'(NR - 1);
    last_j = j_q == JW'(NS - 1);
    h_rd = h_mem[{i_q, k_q}];
    cb_rd = cb_mem[{q_q, k_q, j_q}];
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !bus.start ? IDLE : bus.q_first > bus.q_last ? DONE : bus.reuse_h ? CALC : LOAD_H;
      LOAD_H: state_d = bus.h_valid && h_cnt_q == (RW+KW)'(NR * NT - 1) ? CALC : LOAD_H;
      CALC: state_d = last_k ? OUT : CALC;
      OUT: state_d = !hs ? OUT : q_q == q_last_q && last_i && last_j ? DONE : CALC;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      q_q <= '0;
      q_last_q <= '0;
      i_q <= '0;
      k_q <= '0;
      j_q <= '0;
      h_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        q_q <= bus.q_first;
        q_last_q <= bus.q_last;
        i_q <= '0;
        k_q <= '0;
        j_q <= '0;
        h_cnt_q <= '0;
      end
      if (state_q == LOAD_H && bus.h_valid) h_cnt_q <= h_cnt_q + 1'b1;
      if (state_q == CALC) k_q <= last_k ? '0 : k_q + 1'b1;
      if (hs) begin
        j_q <= last_j ? '0 : j_q + 1'b1;
        if (last_j) i_q <= last_i ? '0 : i_q + 1'b1;
        if (last_j && last_i) q_q <= q_q + 1'b1;
      end
    end
  always_ff @(posedge clk) begin
    if (state_q == LOAD_H && bus.h_valid) h_mem[h_cnt_q] <= {bus.h_in_r, bus.h_in_i};
    if (state_q == IDLE && bus.cb_wr_en) cb_mem[bus.cb_wr_addr] <= {bus.cb_wr_r, bus.cb_wr_i};
  end
  c_mac_acc #(.N(N), .Q(Q), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(state_q == CALC && k_q == '0),
    .en(state_q == CALC),
    .ar(h_rd[2*N-1:N]),
    .ai(h_rd[N-1:0]),
    .br(cb_rd[2*N-1:N]),
    .bi(cb_rd[N-1:0]),
    .yr(y_r),
    .yi(y_i)
  );
  assign bus.h_ready = state_q == LOAD_H;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_r = y_r;
  assign bus.out_i = y_i;
  assign bus.out_q = q_q;
  assign bus.out_row = i_q;
  assign bus.out_col = j_q;
  assign bus.matrix_done = state_q == OUT && last_i && last_j;
  assign bus.all_done = state_q == DONE;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_hq_codebook_mult.sv
// tb_hq_codebook_mult: directed self-checking bench for hq_codebook_mult
module tb_hq_codebook_mult;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int h_r[16], h_i[16];
  int g_r[128], g_i[128], g_q[128], g_row[128], g_col[128], g_md[128];
  int n_out, hr_cnt, first_ov, ad_cyc, last_hs, ov_cnt;
  bit frozen;
  hq_codebook_mult_if bus ();
  hq_codebook_mult dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cbw(input int q, input int k, input int j, input int r, input int im);
    bus.cb_wr_en = 1'b1;
    bus.cb_wr_addr = 7'(q * 8 + k * 2 + j);
    bus.cb_wr_r = 16'(r);
    bus.cb_wr_i = 16'(im);
    tick;
    bus.cb_wr_en = 1'b0;
  endtask
  function automatic int cb_re(input int q, input int k, input int j);
    return ((k + j) % 2 == 1) ? -(128 + q) : 128 + q;
  endfunction
  task automatic job(input bit reuse, input int qf, input int ql, input int stall_at, input bit wr_busy);
    int hidx = 0, cyc = 0, stall = 0, s_r = 0, s_i = 0, s_t = 0, t;
    n_out = 0; hr_cnt = 0; first_ov = 0; ad_cyc = 0; last_hs = 0; ov_cnt = 0; frozen = 1'b1;
    bus.cb_wr_addr = '0; bus.cb_wr_r = 16'sd5000; bus.cb_wr_i = '0;
    bus.reuse_h = reuse; bus.q_first = 4'(qf); bus.q_last = 4'(ql);
    bus.h_valid = 1'b1; bus.out_ready = 1'b1; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    while (ad_cyc == 0 && cyc < 3000) begin
      cyc++;
      bus.cb_wr_en = wr_busy && cyc == 1;
      if (bus.h_ready) begin
        bus.h_in_r = 16'(h_r[hidx % 16]);
        bus.h_in_i = 16'(h_i[hidx % 16]);
        hidx++;
        hr_cnt++;
      end
      if (bus.out_valid) begin
        ov_cnt++;
        if (first_ov == 0) first_ov = cyc;
        t = int'({bus.out_q, bus.out_row, bus.out_col, bus.matrix_done});
        if (n_out == stall_at && stall < 5) begin
          if (stall == 0) begin s_r = int'(bus.out_r); s_i = int'(bus.out_i); s_t = t; end
          else if (s_r != int'(bus.out_r) || s_i != int'(bus.out_i) || s_t != t) frozen = 1'b0;
          stall++;
          bus.out_ready = 1'b0;
        end else begin
          if (n_out == stall_at && (s_r != int'(bus.out_r) || s_i != int'(bus.out_i) || s_t != t)) frozen = 1'b0;
          bus.out_ready = 1'b1;
          if (n_out < 128) begin
            g_r[n_out] = int'(bus.out_r); g_i[n_out] = int'(bus.out_i);
            g_q[n_out] = int'(bus.out_q); g_row[n_out] = int'(bus.out_row);
            g_col[n_out] = int'(bus.out_col); g_md[n_out] = int'(bus.matrix_done);
          end
          n_out++;
          last_hs = cyc;
        end
      end
      if (bus.all_done) ad_cyc = cyc;
      tick;
    end
    bus.cb_wr_en = 1'b0;
    bus.h_valid = 1'b0;
    chk("job_all_done_seen", int'(ad_cyc != 0), 1);
  endtask
  task automatic chk_elems(input int qf, input int cnt);
    for (int e = 0; e < cnt; e++) begin
      int q = qf + e / 8, i = (e % 8) / 2, j = e % 2;
      chk($sformatf("elem%0d_r", e), g_r[e], cb_re(q, i, j));
      chk($sformatf("elem%0d_i", e), g_i[e], q * 8 + i * 2 + j);
      chk($sformatf("elem%0d_q", e), g_q[e], q);
      chk($sformatf("elem%0d_row", e), g_row[e], i);
      chk($sformatf("elem%0d_col", e), g_col[e], j);
      chk($sformatf("elem%0d_mdone", e), g_md[e], int'(e % 8 == 7));
    end
  endtask
  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_h_ready"}, int'(bus.h_ready), 0);
    chk({pfx, "_out_valid"}, int'(bus.out_valid), 0);
    chk({pfx, "_out_r"}, int'(bus.out_r), 0);
    chk({pfx, "_out_i"}, int'(bus.out_i), 0);
    chk({pfx, "_out_q"}, int'(bus.out_q), 0);
    chk({pfx, "_out_row"}, int'(bus.out_row), 0);
    chk({pfx, "_out_col"}, int'(bus.out_col), 0);
    chk({pfx, "_matrix_done"}, int'(bus.matrix_done), 0);
    chk({pfx, "_all_done"}, int'(bus.all_done), 0);
    chk({pfx, "_busy"}, int'(bus.busy), 0);
  endtask
  initial begin
    bus.start = 0; bus.reuse_h = 0; bus.q_first = 0; bus.q_last = 0;
    bus.h_valid = 0; bus.h_in_r = 0; bus.h_in_i = 0;
    bus.cb_wr_en = 0; bus.cb_wr_addr = 0; bus.cb_wr_r = 0; bus.cb_wr_i = 0; bus.out_ready = 1;
    repeat (3) tick;
    chk_idle_outputs("reset");
    rst = 1'b1;
    for (int q = 0; q < 16; q++)
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 2; j++) cbw(q, k, j, cb_re(q, k, j), q * 8 + k * 2 + j);
    for (int e = 0; e < 16; e++) begin h_r[e] = (e / 4 == e % 4) ? 256 : 0; h_i[e] = 0; end
    job(0, 0, 0, -1, 0);
    chk("ident_count", n_out, 8);
    chk("ident_latency", first_ov, 21);
    chk("ident_h_beats", hr_cnt, 16);
    chk_elems(0, 8);
    chk("ident_all_done_cycle", ad_cyc, last_hs + 1);
    chk("ident_all_done_pulse", int'(bus.all_done), 0);
    chk("ident_idle", int'(bus.busy), 0);
    job(0, 0, 15, 3, 0);
    chk("range_count", n_out, 128);
    chk("range_latency", first_ov, 21);
    chk("stall_frozen", int'(frozen), 1);
    chk("range_valid_cycles", ov_cnt, 128 + 5);
    chk_elems(0, 128);
    chk("range_all_done_cycle", ad_cyc, last_hs + 1);
    job(1, 5, 6, -1, 0);
    chk("reuse_h_beats", hr_cnt, 0);
    chk("reuse_count", n_out, 16);
    chk("reuse_latency", first_ov, 5);
    chk_elems(5, 16);
    bus.reuse_h = 1; bus.q_first = 4'd2; bus.q_last = 4'd2; bus.start = 1;
    tick;
    bus.start = 0;
    tick;
    chk("midcalc_busy", int'(bus.busy), 1);
    chk("midcalc_out_r", int'(bus.out_r), 130);
    chk("midcalc_out_q", int'(bus.out_q), 2);
    rst = 1'b0;
    tick;
    chk_idle_outputs("midreset");
    rst = 1'b1;
    tick;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) cbw(0, k, j, 32767, 0);
    for (int e = 0; e < 16; e++) begin h_r[e] = 32767; h_i[e] = 0; end
    job(0, 0, 0, -1, 0);
    chk("sat_count", n_out, 8);
    for (int e = 0; e < 8; e++) begin
      chk($sformatf("sat%0d_r", e), g_r[e], 32767);
      chk($sformatf("sat%0d_i", e), g_i[e], 0);
    end
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) cbw(0, k, j, 128, 0);
    for (int e = 0; e < 16; e++) h_r[e] = 0;
    h_r[0] = 1;
    job(0, 0, 0, -1, 0);
    for (int e = 0; e < 8; e++) begin
      chk($sformatf("round_pos%0d_r", e), g_r[e], e < 2 ? 1 : 0);
      chk($sformatf("round_pos%0d_i", e), g_i[e], 0);
    end
    h_r[0] = -1;
    job(0, 0, 0, -1, 0);
    for (int e = 0; e < 8; e++) chk($sformatf("round_neg%0d_r", e), g_r[e], 0);
    job(1, 3, 2, -1, 1);
    chk("empty_all_done_cycle", ad_cyc, 1);
    chk("empty_no_valid", ov_cnt, 0);
    chk("empty_h_beats", hr_cnt, 0);
    job(1, 0, 0, -1, 0);
    chk("busy_write_ignored_r", g_r[0], 0);
    chk("busy_write_ignored_i", g_i[0], 0);
    chk("final_count", n_out, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
